// File: rtl/vga_scan_gen_if.sv
// Raster-scan bundle between vga_scan_gen and its downstream consumers.
// The generator drives everything except the pixel-advance enable.
interface vga_scan_gen_if;
    logic       ena;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;

    modport master (
        input  ena,
        output x, y, active, hsync, vsync, line_start, frame_start, frame_cnt
    );

    modport slave (
        output ena,
        input  x, y, active, hsync, vsync, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: free-running pixel/line counters with registered
// active/hsync/vsync decodes aligned to x/y, plus line/frame strobes and a
// frame counter. Reset parks the scan on the last blanking pixel so the first
// enabled clock presents pixel (0,0).
module vga_scan_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_scan_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    // Next-state counters; decodes are taken from the next-state values so
    // they land in the same edge as x/y with no skew.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        fcnt_d   = fcnt_q;
        active_d = active_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        if (vga.ena) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d    = '0;
                    fcnt_d = fcnt_q + 8'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
            active_d = (x_d < H_VIS) && (y_d < V_VIS);
            hsync_d  = (x_d >= HS_START && x_d < HS_END) ? SYNC_ON : SYNC_OFF;
            vsync_d  = (y_d >= VS_START && y_d < VS_END) ? SYNC_ON : SYNC_OFF;
        end
    end

    // Scan state registers with asynchronous reset to the last blanking pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= H_LAST;
            y_q      <= V_LAST;
            fcnt_q   <= '0;
            active_q <= 1'b0;
            hsync_q  <= SYNC_OFF;
            vsync_q  <= SYNC_OFF;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            fcnt_q   <= fcnt_d;
            active_q <= active_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.active      = active_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.frame_cnt   = fcnt_q;
    // Strobes mark the pixel being consumed this clock, so they are gated by ena.
    assign vga.line_start  = vga.ena && (x_q == '0);
    assign vga.frame_start = vga.ena && (x_q == '0) && (y_q == '0);

endmodule
